// File: rtl/dll_mq.sv
// dll_mq: M doubly-linked lists sharing one pool of N W-bit entries.
// Latency: every accepted command completes in one cycle; pop/error response is registered (t+1).
// Backpressure: cmd_rdy is low while the free list is being built (busy_r) or while clear is asserted.
module dll_mq #(
  parameter int W = 32,
  parameter int N = 16,
  parameter int M = 4,
  localparam int IDW = (M > 1) ? $clog2(M) : 1,
  localparam int PW  = $clog2(N),
  localparam int CW  = $clog2(N + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cmd_vld,
  output logic           cmd_rdy,
  input  logic [1:0]     cmd_op,
  input  logic [IDW-1:0] cmd_id,
  input  logic [W-1:0]   cmd_push_data,
  output logic           rsp_vld_r,
  output logic           rsp_err_r,
  output logic [W-1:0]   rsp_data_r,
  input  logic           clear,
  output logic           full_r,
  output logic           empty_r,
  output logic [M-1:0]   nempty_r,
  output logic [CW-1:0]  occupancy_r,
  output logic           busy_r
);

  localparam logic [IDW:0]  M_L   = (IDW + 1)'(M);
  localparam logic [PW-1:0] LAST  = PW'(N - 1);
  localparam logic [CW-1:0] N_CW  = CW'(N);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  // Storage arrays: payload and link pointers (no reset; init sequence builds links)
  logic [W-1:0]  r_data [N];
  logic [PW-1:0] r_next [N];
  logic [PW-1:0] r_prev [N];

  // Per-list end pointers and control state
  logic [PW-1:0] r_head [M];
  logic [PW-1:0] r_tail [M];
  logic [M-1:0]  r_nempty;
  logic [PW-1:0] r_free_head;
  logic [CW-1:0] r_occ;
  logic [PW-1:0] r_cnt;
  logic          r_busy;
  logic          r_full;
  logic          r_empty;
  logic          r_rsp_vld;
  logic          r_rsp_err;
  logic [W-1:0]  r_rsp_data;

  logic           w_acc;
  logic           w_id_ok;
  logic [IDW-1:0] w_idx;
  logic           w_is_push;
  logic           w_front;
  logic           w_ne;
  logic           w_err;
  logic           w_ok;
  logic [PW-1:0]  w_head;
  logic [PW-1:0]  w_tail;
  logic [PW-1:0]  w_pop_e;
  logic [PW-1:0]  w_new_e;

  assign cmd_rdy = ~r_busy & ~clear;

  // Decode the command and classify it as success or error
  always_comb begin
    w_acc     = cmd_vld & cmd_rdy;
    w_id_ok   = ({1'b0, cmd_id} < M_L);
    w_idx     = w_id_ok ? cmd_id : '0;
    w_is_push = ~cmd_op[1];
    w_front   = ~cmd_op[0];
    w_ne      = r_nempty[w_idx];
    w_err     = ~w_id_ok | (w_is_push ? r_full : ~w_ne);
    w_ok      = w_acc & ~w_err;
    w_head    = r_head[w_idx];
    w_tail    = r_tail[w_idx];
    w_pop_e   = w_front ? w_head : w_tail;
    w_new_e   = r_free_head;
  end

  // Array writes: init links the free chain, push links a new entry, pop returns to free head
  always_ff @(posedge clk) begin
    if (r_busy) begin
      r_next[r_cnt] <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end else if (w_ok) begin
      if (w_is_push) begin
        r_data[w_new_e] <= cmd_push_data;
        if (w_ne) begin
          if (w_front) begin
            r_next[w_new_e] <= w_head;
            r_prev[w_head]  <= w_new_e;
          end else begin
            r_prev[w_new_e] <= w_tail;
            r_next[w_tail]  <= w_new_e;
          end
        end
      end else begin
        r_next[w_pop_e] <= r_free_head;
      end
    end
  end

  // Control: reset/clear start init, init counts N cycles, then one command per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy      <= 1'b1;
      r_cnt       <= '0;
      r_occ       <= '0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_nempty    <= '0;
      r_free_head <= '0;
      r_rsp_vld   <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_data  <= '0;
      for (int i = 0; i < M; i++) begin
        r_head[i] <= '0;
        r_tail[i] <= '0;
      end
    end else begin
      r_rsp_vld <= 1'b0;
      if (clear) begin
        r_busy      <= 1'b1;
        r_cnt       <= '0;
        r_occ       <= '0;
        r_full      <= 1'b0;
        r_empty     <= 1'b1;
        r_nempty    <= '0;
        r_free_head <= '0;
      end else if (r_busy) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == LAST) r_busy <= 1'b0;
      end else if (w_acc) begin
        if (w_err) begin
          r_rsp_vld  <= 1'b1;
          r_rsp_err  <= 1'b1;
          r_rsp_data <= '0;
        end else if (w_is_push) begin
          r_free_head     <= r_next[w_new_e];
          r_occ           <= r_occ + 1'b1;
          r_full          <= ((r_occ + 1'b1) == N_CW);
          r_empty         <= 1'b0;
          r_nempty[w_idx] <= 1'b1;
          if (!w_ne) begin
            r_head[w_idx] <= w_new_e;
            r_tail[w_idx] <= w_new_e;
          end else if (w_front) begin
            r_head[w_idx] <= w_new_e;
          end else begin
            r_tail[w_idx] <= w_new_e;
          end
        end else begin
          r_rsp_vld   <= 1'b1;
          r_rsp_err   <= 1'b0;
          r_rsp_data  <= r_data[w_pop_e];
          r_free_head <= w_pop_e;
          r_occ       <= r_occ - 1'b1;
          r_full      <= 1'b0;
          r_empty     <= (r_occ == ONE_C);
          if (w_head == w_tail) begin
            r_nempty[w_idx] <= 1'b0;
          end else if (w_front) begin
            r_head[w_idx] <= r_next[w_head];
          end else begin
            r_tail[w_idx] <= r_prev[w_tail];
          end
        end
      end
    end
  end

  assign rsp_vld_r   = r_rsp_vld;
  assign rsp_err_r   = r_rsp_err;
  assign rsp_data_r  = r_rsp_data;
  assign full_r      = r_full;
  assign empty_r     = r_empty;
  assign nempty_r    = r_nempty;
  assign occupancy_r = r_occ;
  assign busy_r      = r_busy;

endmodule

// File: tb/tb_dll_mq.sv
// tb_dll_mq: directed stimulus for dll_mq with a queue scoreboard.
// Expected pop/error responses are queued at issue time and checked by a negedge monitor.
// A second small instance (M=3) exercises out-of-range list ids.
module tb_dll_mq;

  localparam logic [1:0] PF = 2'd0;
  localparam logic [1:0] PB = 2'd1;
  localparam logic [1:0] QF = 2'd2;
  localparam logic [1:0] QB = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_vld = 1'b0;
  logic        cmd_rdy;
  logic [1:0]  cmd_op = '0;
  logic [1:0]  cmd_id = '0;
  logic [31:0] cmd_push_data = '0;
  logic        rsp_vld_r, rsp_err_r;
  logic [31:0] rsp_data_r;
  logic        clear = 1'b0;
  logic        full_r, empty_r, busy_r;
  logic [3:0]  nempty_r;
  logic [4:0]  occupancy_r;

  // second instance with M=3
  logic        c3_vld = 1'b0;
  logic        c3_rdy;
  logic [1:0]  c3_op = '0;
  logic [1:0]  c3_id = '0;
  logic        x3_vld, x3_err, x3_full, x3_empty, x3_busy;
  logic [31:0] x3_data;
  logic [2:0]  x3_nempty;
  logic [4:0]  x3_occ;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        err;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  dll_mq #(.W(32), .N(16), .M(4)) dut (
    .clk(clk), .rst(rst), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_op(cmd_op),
    .cmd_id(cmd_id), .cmd_push_data(cmd_push_data), .rsp_vld_r(rsp_vld_r),
    .rsp_err_r(rsp_err_r), .rsp_data_r(rsp_data_r), .clear(clear), .full_r(full_r),
    .empty_r(empty_r), .nempty_r(nempty_r), .occupancy_r(occupancy_r), .busy_r(busy_r)
  );

  dll_mq #(.W(32), .N(16), .M(3)) dut3 (
    .clk(clk), .rst(rst), .cmd_vld(c3_vld), .cmd_rdy(c3_rdy), .cmd_op(c3_op),
    .cmd_id(c3_id), .cmd_push_data(32'h77), .rsp_vld_r(x3_vld),
    .rsp_err_r(x3_err), .rsp_data_r(x3_data), .clear(1'b0), .full_r(x3_full),
    .empty_r(x3_empty), .nempty_r(x3_nempty), .occupancy_r(x3_occ), .busy_r(x3_busy)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Issue one command for one cycle; queue the expected response if any
  task automatic cmd(input logic [1:0] op, input logic [1:0] id, input logic [31:0] d,
                     input bit exp_rsp, input bit exp_err, input logic [31:0] exp_d);
    exp_t e;
    chk("cmd_rdy", {63'd0, cmd_rdy}, 64'd1);
    cmd_vld = 1'b1;
    cmd_op = op;
    cmd_id = id;
    cmd_push_data = d;
    if (exp_rsp) begin
      e.err = exp_err;
      e.data = exp_d;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    cmd_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Count cycles with busy_r high, then check ready in the first free cycle
  task automatic count_busy(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    if (busy_r) chk({nm, "_rdy_init"}, {63'd0, cmd_rdy}, 64'd0);
    while (busy_r && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk({nm, "_busy_cycles"}, 64'(n), 64'd16);
    chk({nm, "_rdy_after"}, {63'd0, cmd_rdy}, 64'd1);
    @(posedge clk); #1;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && rsp_vld_r) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_rsp: got err=%0b data=%0h want none", rsp_err_r, rsp_data_r);
      end else begin
        e = sb.pop_front();
        chk("rsp_err", {63'd0, rsp_err_r}, {63'd0, e.err});
        chk("rsp_data", {32'd0, rsp_data_r}, {32'd0, e.data});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

  initial begin
    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {63'd0, busy_r}, 64'd1);
    chk("rst_full", {63'd0, full_r}, 64'd0);
    chk("rst_empty", {63'd0, empty_r}, 64'd1);
    chk("rst_nempty", {60'd0, nempty_r}, 64'd0);
    chk("rst_occ", {59'd0, occupancy_r}, 64'd0);
    chk("rst_rsp", {31'd0, rsp_vld_r, rsp_err_r, rsp_data_r}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    count_busy("init");
    chk("init_empty", {63'd0, empty_r}, 64'd1);
    chk("init_full", {63'd0, full_r}, 64'd0);

    // list 0 FIFO order
    cmd(PB, 2'd0, 32'hA, 0, 0, 0);
    cmd(PB, 2'd0, 32'hB, 0, 0, 0);
    cmd(PB, 2'd0, 32'hC, 0, 0, 0);
    chk("l0_occ3", {59'd0, occupancy_r}, 64'd3);
    chk("l0_nempty", {60'd0, nempty_r}, 64'h1);
    cmd(QF, 2'd0, 0, 1, 0, 32'hA);
    cmd(QF, 2'd0, 0, 1, 0, 32'hB);
    cmd(QF, 2'd0, 0, 1, 0, 32'hC);
    chk("l0_nempty_after", {60'd0, nempty_r}, 64'h0);
    chk("l0_empty_after", {63'd0, empty_r}, 64'd1);
    idle(2);

    // list 2 push front, pop back/front
    cmd(PF, 2'd2, 32'd1, 0, 0, 0);
    cmd(PF, 2'd2, 32'd2, 0, 0, 0);
    cmd(PF, 2'd2, 32'd3, 0, 0, 0);
    chk("l2_occ3", {59'd0, occupancy_r}, 64'd3);
    cmd(QB, 2'd2, 0, 1, 0, 32'd1);
    cmd(QB, 2'd2, 0, 1, 0, 32'd2);
    cmd(QF, 2'd2, 0, 1, 0, 32'd3);
    chk("l2_occ0", {59'd0, occupancy_r}, 64'd0);
    idle(2);

    // interleaved lists
    cmd(PB, 2'd1, 32'h11, 0, 0, 0);
    cmd(PB, 2'd3, 32'h33, 0, 0, 0);
    cmd(PB, 2'd1, 32'h12, 0, 0, 0);
    chk("il_nempty", {60'd0, nempty_r}, 64'hA);
    cmd(QF, 2'd1, 0, 1, 0, 32'h11);
    cmd(QF, 2'd1, 0, 1, 0, 32'h12);
    cmd(QB, 2'd3, 0, 1, 0, 32'h33);
    chk("il_empty", {63'd0, empty_r}, 64'd1);
    idle(2);

    // fill the pool, overflow, drain partially
    for (int i = 0; i < 16; i++) cmd(PB, 2'(i % 4), 32'h100 + 32'(i), 0, 0, 0);
    chk("fill_full", {63'd0, full_r}, 64'd1);
    chk("fill_occ", {59'd0, occupancy_r}, 64'd16);
    cmd(PB, 2'd0, 32'hDEAD, 1, 1, 32'd0);
    chk("ovf_occ", {59'd0, occupancy_r}, 64'd16);
    chk("ovf_full", {63'd0, full_r}, 64'd1);
    for (int i = 0; i < 4; i++) cmd(QF, 2'd0, 0, 1, 0, 32'h100 + 32'(4 * i));
    cmd(QF, 2'd0, 0, 1, 1, 32'd0);
    for (int i = 0; i < 4; i++) cmd(QF, 2'd1, 0, 1, 0, 32'h101 + 32'(4 * i));
    for (int i = 0; i < 3; i++) cmd(QF, 2'd2, 0, 1, 0, 32'h102 + 32'(4 * i));
    chk("drain_occ5", {59'd0, occupancy_r}, 64'd5);
    chk("drain_nempty", {60'd0, nempty_r}, 64'hC);
    chk("drain_full", {63'd0, full_r}, 64'd0);
    idle(2);

    // clear alongside a push
    clear = 1'b1;
    cmd_vld = 1'b1;
    cmd_op = PB;
    cmd_id = 2'd0;
    cmd_push_data = 32'h99;
    #1;
    chk("clr_rdy", {63'd0, cmd_rdy}, 64'd0);
    @(posedge clk); #1;
    clear = 1'b0;
    cmd_vld = 1'b0;
    count_busy("clr");
    chk("clr_occ", {59'd0, occupancy_r}, 64'd0);
    chk("clr_nempty", {60'd0, nempty_r}, 64'h0);
    cmd(QF, 2'd3, 0, 1, 1, 32'd0);
    cmd(PB, 2'd0, 32'h55, 0, 0, 0);
    cmd(QB, 2'd0, 0, 1, 0, 32'h55);
    idle(3);

    // out-of-range list id on the M=3 instance
    c3_vld = 1'b1;
    c3_op = PB;
    c3_id = 2'd3;
    @(posedge clk); #1;
    c3_vld = 1'b0;
    chk("id3_push_rsp", {62'd0, x3_vld, x3_err}, 64'd3);
    chk("id3_push_data", {32'd0, x3_data}, 64'd0);
    chk("id3_push_occ", {59'd0, x3_occ}, 64'd0);
    c3_vld = 1'b1;
    c3_op = QF;
    c3_id = 2'd3;
    @(posedge clk); #1;
    c3_vld = 1'b0;
    chk("id3_pop_rsp", {62'd0, x3_vld, x3_err}, 64'd3);

    idle(3);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
